// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch and data access.
// Data wins ties, flushed fetches are discarded, and a wait counter aborts accesses to a dead slave.
module mem_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TO_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_sel,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_timeout
);

  localparam int CNT_W = $clog2(TO_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_IF_BUSY = 3'd1,
    S_DM_BUSY = 3'd2,
    S_IF_DONE = 3'd3,
    S_DM_DONE = 3'd4
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_discard;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [3:0]        r_bus_sel;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic              r_timeout;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  logic w_to_hit;
  logic w_if_drop;

  // An ack in the final wait cycle wins over the timeout.
  assign w_to_hit  = (r_cnt == CNT_LAST) & ~bus_ack;
  assign w_if_drop = r_discard | flush;

  assign if_stall    = if_req & (r_state != S_IF_DONE);
  assign dm_stall    = dm_req & (r_state != S_DM_DONE);
  assign bus_req     = r_bus_req;
  assign bus_we      = r_bus_we;
  assign bus_sel     = r_bus_sel;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign bus_timeout = r_timeout;
  assign if_rdata    = r_if_rdata;
  assign dm_rdata    = r_dm_rdata;

  // Arbitration FSM with registered bus and read-data outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_discard   <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_sel   <= 4'h0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_timeout   <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt     <= '0;
          r_discard <= 1'b0;
          if (dm_req) begin
            r_state     <= S_DM_BUSY;
            r_bus_req   <= 1'b1;
            r_bus_we    <= dm_we;
            r_bus_sel   <= dm_sel;
            r_bus_addr  <= dm_addr;
            r_bus_wdata <= dm_wdata;
          end else if (if_req && !flush) begin
            r_state     <= S_IF_BUSY;
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= 4'hF;
            r_bus_addr  <= if_addr;
            r_bus_wdata <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_IF_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (flush) begin
            r_discard <= 1'b1;
          end
          if (bus_ack || w_to_hit) begin
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            r_cnt     <= '0;
            r_discard <= 1'b0;
            r_timeout <= ~bus_ack;
            // A flushed fetch completes on the bus but never reaches the pipeline.
            if (w_if_drop) begin
              r_state <= S_IDLE;
            end else begin
              r_state    <= S_IF_DONE;
              r_if_rdata <= bus_ack ? bus_rdata : '0;
            end
          end
        end
        S_DM_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (bus_ack || w_to_hit) begin
            r_state   <= S_DM_DONE;
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            r_cnt     <= '0;
            r_timeout <= ~bus_ack;
            if (!r_bus_we) begin
              r_dm_rdata <= bus_ack ? bus_rdata : '0;
            end
          end
        end
        S_IF_DONE: r_state <= S_IDLE;
        S_DM_DONE: r_state <= S_IDLE;
        default: begin
          r_state   <= S_IDLE;
          r_bus_req <= 1'b0;
          r_bus_we  <= 1'b0;
          r_cnt     <= '0;
          r_discard <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Cycle-by-cycle vector bench for mem_bus_arbiter (TO_CYCLES=4), plus a
// hand-written fetch-timeout sequence with a bounded wait.
module tb_mem_bus_arbiter;

  localparam logic        H    = 1'b1;
  localparam logic        L    = 1'b0;
  localparam logic [31:0] A_IF = 32'h0000_0100;
  localparam logic [31:0] A_DM = 32'h0000_0200;
  localparam logic [31:0] WD   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst, flush, if_req, dm_req, dm_we, bus_ack;
  logic [3:0]  dm_sel;
  logic [31:0] if_addr, dm_addr, dm_wdata, bus_rdata;
  logic [31:0] if_rdata, dm_rdata, bus_addr, bus_wdata;
  logic        if_stall, dm_stall, bus_req, bus_we, bus_timeout;
  logic [3:0]  bus_sel;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic rst, flush, ifr, dmr, we;
    logic [3:0] sel;
    logic ack;
    logic [31:0] rdata;
    logic e_ifs, e_dms, e_breq, e_bwe;
    logic [3:0] e_bsel;
    logic [31:0] e_baddr;
    logic e_bto;
    logic [31:0] e_ifrd, e_dmrd;
  } vec_t;

  vec_t vq[$];

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TO_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  initial begin
    int n_req, n_to;
    bit served;

    // rst fl ifr dmr we sel ack rdata | ifs dms breq bwe bsel baddr bto ifrd dmrd
    vq.push_back('{L,L,H,L,L,4'h0,H,32'h0000_FFFF, H,L,L,L,4'h0,32'h0,L,32'h0,32'h0});
    vq.push_back('{L,H,L,H,H,4'hF,L,32'h0,         L,H,L,L,4'h0,32'h0,L,32'h0,32'h0});
    vq.push_back('{L,H,H,H,L,4'h3,H,32'h0000_AAAA, H,H,L,L,4'h0,32'h0,L,32'h0,32'h0});
    // plain fetch, ack two cycles after bus_req rises
    vq.push_back('{H,L,H,L,L,4'h0,L,32'h0,         H,L,L,L,4'h0,32'h0,L,32'h0,32'h0});
    vq.push_back('{H,L,H,L,L,4'h0,L,32'h0,         H,L,H,L,4'hF,A_IF, L,32'h0,32'h0});
    vq.push_back('{H,L,H,L,L,4'h0,L,32'h0,         H,L,H,L,4'hF,A_IF, L,32'h0,32'h0});
    vq.push_back('{H,L,H,L,L,4'h0,H,32'h2402_0001, H,L,H,L,4'hF,A_IF, L,32'h0,32'h0});
    vq.push_back('{H,L,H,L,L,4'h0,L,32'h0,         L,L,L,L,4'h0,32'h0,L,32'h2402_0001,32'h0});
    vq.push_back('{H,H,H,L,L,4'h0,L,32'h0,         H,L,L,L,4'h0,32'h0,L,32'h2402_0001,32'h0});
    vq.push_back('{H,L,L,L,L,4'h0,L,32'h0,         L,L,L,L,4'h0,32'h0,L,32'h2402_0001,32'h0});
    // contention: store first, then fetch
    vq.push_back('{H,L,H,H,H,4'h3,L,32'h0,         H,H,L,L,4'h0,32'h0,L,32'h2402_0001,32'h0});
    vq.push_back('{H,L,H,H,H,4'h3,L,32'h0,         H,H,H,H,4'h3,A_DM, L,32'h2402_0001,32'h0});
    vq.push_back('{H,L,H,H,H,4'h3,H,32'h0000_0055, H,H,H,H,4'h3,A_DM, L,32'h2402_0001,32'h0});
    vq.push_back('{H,L,H,H,H,4'h3,L,32'h0,         H,L,L,L,4'h0,32'h0,L,32'h2402_0001,32'h0});
    vq.push_back('{H,L,H,L,L,4'h0,L,32'h0,         H,L,L,L,4'h0,32'h0,L,32'h2402_0001,32'h0});
    vq.push_back('{H,L,H,L,L,4'h0,H,32'hA5A5_0001, H,L,H,L,4'hF,A_IF, L,32'h2402_0001,32'h0});
    vq.push_back('{H,L,H,L,L,4'h0,L,32'h0,         L,L,L,L,4'h0,32'h0,L,32'hA5A5_0001,32'h0});
    vq.push_back('{H,L,L,L,L,4'h0,L,32'h0,         L,L,L,L,4'h0,32'h0,L,32'hA5A5_0001,32'h0});
    // flush during fetch, then refetch
    vq.push_back('{H,L,H,L,L,4'h0,L,32'h0,         H,L,L,L,4'h0,32'h0,L,32'hA5A5_0001,32'h0});
    vq.push_back('{H,H,H,L,L,4'h0,L,32'h0,         H,L,H,L,4'hF,A_IF, L,32'hA5A5_0001,32'h0});
    vq.push_back('{H,L,H,L,L,4'h0,L,32'h0,         H,L,H,L,4'hF,A_IF, L,32'hA5A5_0001,32'h0});
    vq.push_back('{H,L,H,L,L,4'h0,H,32'h0000_1234, H,L,H,L,4'hF,A_IF, L,32'hA5A5_0001,32'h0});
    vq.push_back('{H,L,H,L,L,4'h0,L,32'h0,         H,L,L,L,4'h0,32'h0,L,32'hA5A5_0001,32'h0});
    vq.push_back('{H,L,H,L,L,4'h0,H,32'h0BAD_F00D, H,L,H,L,4'hF,A_IF, L,32'hA5A5_0001,32'h0});
    vq.push_back('{H,L,H,L,L,4'h0,L,32'h0,         L,L,L,L,4'h0,32'h0,L,32'h0BAD_F00D,32'h0});
    vq.push_back('{H,L,L,L,L,4'h0,L,32'h0,         L,L,L,L,4'h0,32'h0,L,32'h0BAD_F00D,32'h0});
    // load acked, then load timeout, then ack on the last wait cycle
    vq.push_back('{H,L,L,H,L,4'hF,L,32'h0,         L,H,L,L,4'h0,32'h0,L,32'h0BAD_F00D,32'h0});
    vq.push_back('{H,L,L,H,L,4'hF,H,32'hCAFE_0001, L,H,H,L,4'hF,A_DM, L,32'h0BAD_F00D,32'h0});
    vq.push_back('{H,L,L,H,L,4'hF,L,32'h0,         L,L,L,L,4'h0,32'h0,L,32'h0BAD_F00D,32'hCAFE_0001});
    vq.push_back('{H,L,L,H,L,4'hF,L,32'h0,         L,H,L,L,4'h0,32'h0,L,32'h0BAD_F00D,32'hCAFE_0001});
    for (int i = 0; i < 4; i++)
      vq.push_back('{H,L,L,H,L,4'hF,L,32'h0,       L,H,H,L,4'hF,A_DM, L,32'h0BAD_F00D,32'hCAFE_0001});
    vq.push_back('{H,L,L,H,L,4'hF,L,32'h0,         L,L,L,L,4'h0,32'h0,H,32'h0BAD_F00D,32'h0});
    vq.push_back('{H,L,L,L,L,4'hF,L,32'h0,         L,L,L,L,4'h0,32'h0,L,32'h0BAD_F00D,32'h0});
    vq.push_back('{H,L,L,H,L,4'hF,L,32'h0,         L,H,L,L,4'h0,32'h0,L,32'h0BAD_F00D,32'h0});
    for (int i = 0; i < 3; i++)
      vq.push_back('{H,L,L,H,L,4'hF,L,32'h0,       L,H,H,L,4'hF,A_DM, L,32'h0BAD_F00D,32'h0});
    vq.push_back('{H,L,L,H,L,4'hF,H,32'h0000_0077, L,H,H,L,4'hF,A_DM, L,32'h0BAD_F00D,32'h0});
    vq.push_back('{H,L,L,H,L,4'hF,L,32'h0,         L,L,L,L,4'h0,32'h0,L,32'h0BAD_F00D,32'h77});
    vq.push_back('{H,L,L,L,L,4'hF,L,32'h0,         L,L,L,L,4'h0,32'h0,L,32'h0BAD_F00D,32'h77});
    // reset in the middle of a store; a late ack must be ignored
    vq.push_back('{H,L,L,H,H,4'hC,L,32'h0,         L,H,L,L,4'h0,32'h0,L,32'h0BAD_F00D,32'h77});
    vq.push_back('{H,L,L,H,H,4'hC,L,32'h0,         L,H,H,H,4'hC,A_DM, L,32'h0BAD_F00D,32'h77});
    vq.push_back('{L,L,L,H,H,4'hC,L,32'h0,         L,H,H,H,4'hC,A_DM, L,32'h0BAD_F00D,32'h77});
    vq.push_back('{H,L,L,L,L,4'h0,H,32'h0000_0099, L,L,L,L,4'h0,32'h0,L,32'h0,32'h0});
    vq.push_back('{H,L,L,L,L,4'h0,L,32'h0,         L,L,L,L,4'h0,32'h0,L,32'h0,32'h0});
    vq.push_back('{H,L,H,L,L,4'h0,L,32'h0,         H,L,L,L,4'h0,32'h0,L,32'h0,32'h0});
    vq.push_back('{H,L,H,L,L,4'h0,H,32'h0000_0011, H,L,H,L,4'hF,A_IF, L,32'h0,32'h0});
    vq.push_back('{H,L,H,L,L,4'h0,L,32'h0,         L,L,L,L,4'h0,32'h0,L,32'h11,32'h0});
    vq.push_back('{H,L,L,L,L,4'h0,L,32'h0,         L,L,L,L,4'h0,32'h0,L,32'h11,32'h0});

    if_addr   = A_IF;
    dm_addr   = A_DM;
    dm_wdata  = WD;
    rst       = 1'b0;
    flush     = 1'b0;
    if_req    = $urandom_range(1, 0) == 1;
    dm_req    = $urandom_range(1, 0) == 1;
    dm_we     = 1'b1;
    dm_sel    = 4'h5;
    bus_ack   = 1'b1;
    bus_rdata = $urandom;
    @(posedge clk);

    foreach (vq[i]) begin
      #1;
      rst = vq[i].rst; flush = vq[i].flush; if_req = vq[i].ifr; dm_req = vq[i].dmr;
      dm_we = vq[i].we; dm_sel = vq[i].sel; bus_ack = vq[i].ack; bus_rdata = vq[i].rdata;
      @(negedge clk);
      check("if_stall", i, {31'h0, if_stall}, {31'h0, vq[i].e_ifs});
      check("dm_stall", i, {31'h0, dm_stall}, {31'h0, vq[i].e_dms});
      check("bus_req", i, {31'h0, bus_req}, {31'h0, vq[i].e_breq});
      check("bus_timeout", i, {31'h0, bus_timeout}, {31'h0, vq[i].e_bto});
      check("if_rdata", i, if_rdata, vq[i].e_ifrd);
      check("dm_rdata", i, dm_rdata, vq[i].e_dmrd);
      if (vq[i].e_breq) begin
        check("bus_we", i, {31'h0, bus_we}, {31'h0, vq[i].e_bwe});
        check("bus_sel", i, {28'h0, bus_sel}, {28'h0, vq[i].e_bsel});
        check("bus_addr", i, bus_addr, vq[i].e_baddr);
        if (vq[i].e_bwe) check("bus_wdata", i, bus_wdata, WD);
      end
      @(posedge clk);
    end

    // Fetch to a dead slave: four wait cycles, one timeout pulse, if_rdata cleared.
    #1;
    rst = 1'b1; flush = 1'b0; dm_req = 1'b0; bus_ack = 1'b0; if_req = 1'b1;
    n_req  = 0;
    n_to   = 0;
    served = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_req) n_req++;
      if (bus_timeout) n_to++;
      if (!if_stall) begin
        served = 1'b1;
        break;
      end
    end
    check("fetch_to_served", 0, {31'h0, served}, 32'h1);
    check("fetch_to_req_cycles", 0, n_req, 32'd4);
    check("fetch_to_pulses", 0, n_to, 32'd1);
    check("fetch_to_rdata", 0, if_rdata, 32'h0);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    @(negedge clk);
    check("fetch_to_idle", 0, {30'h0, bus_req, bus_timeout}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
